// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver (16x oversampled) feeding a first-word-fall-through byte FIFO.
// Define UART_RX_PARITY_EN to receive 8E1 frames with parity checking.
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int SYS_CLK_FREQ   = 100000000,
  parameter int BAUD_RATE      = 115200,
  parameter int FIFO_ADDR_BITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx,
  input  logic                    rd_en,
  input  logic                    err_clr,
  output logic [7:0]              rd_data,
  output logic                    empty,
  output logic                    full,
  output logic [FIFO_ADDR_BITS:0] count,
  output logic                    overflow,
  output logic                    frame_err
);
  localparam int DIV   = SYS_CLK_FREQ / (BAUD_RATE * 16);
  localparam int TW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DEPTH = 1 << FIFO_ADDR_BITS;
  localparam int AW    = FIFO_ADDR_BITS;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;
  logic          r_rx_meta;
  logic          r_rx_s;
  state_t        r_state;
  logic [3:0]    r_s;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [7:0]    r_mem [DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic [AW:0]   w_count;
  logic          r_ovf;
  logic          r_ferr;
  logic          w_stop_done;
  logic          w_good;
  logic          w_pop;
  logic          w_push;
  logic          w_ovf_set;
  logic          w_ferr_set;

  assign w_tick = (r_tick_cnt == TW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt <= '0;
      r_rx_meta  <= 1'b1;
      r_rx_s     <= 1'b1;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
      r_rx_meta  <= rx;
      r_rx_s     <= r_rx_meta;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_err;
  assign w_good = r_rx_s & ~r_par_err;
`else
  assign w_good = r_rx_s;
`endif

  assign w_stop_done = (r_state == S_STOP) & w_tick & (r_s == 4'd15);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_s     <= '0;
      r_bit   <= '0;
      r_shift <= '0;
`ifdef UART_RX_PARITY_EN
      r_par_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            r_state <= S_START;
            r_s     <= '0;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (r_s == 4'd7) begin
              r_s   <= '0;
              r_bit <= '0;
              r_state <= r_rx_s ? S_IDLE : S_DATA;
            end else begin
              r_s <= r_s + 4'd1;
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            if (r_s == 4'd15) begin
              r_s     <= '0;
              r_shift <= {r_rx_s, r_shift[7:1]};
              r_bit   <= r_bit + 3'd1;
              if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                r_state <= S_PARITY;
`else
                r_state <= S_STOP;
`endif
              end
            end else begin
              r_s <= r_s + 4'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_tick) begin
            if (r_s == 4'd15) begin
              // even parity: bit must equal XOR of the data bits
              r_par_err <= r_rx_s ^ (^r_shift);
              r_s       <= '0;
              r_state   <= S_STOP;
            end else begin
              r_s <= r_s + 4'd1;
            end
          end
        end
`endif
        S_STOP: begin
          if (w_tick) begin
            if (r_s == 4'd15) begin
              r_s     <= '0;
              r_state <= S_IDLE;
            end else begin
              r_s <= r_s + 4'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_count    = r_wptr - r_rptr;
  assign empty      = (w_count == '0);
  assign full       = w_count[AW];
  assign count      = w_count;
  assign rd_data    = empty ? 8'h00 : r_mem[r_rptr[AW-1:0]];
  assign w_pop      = rd_en & ~empty;
  assign w_push     = w_stop_done & w_good & (~full | w_pop);
  assign w_ovf_set  = w_stop_done & w_good & full & ~w_pop;
  assign w_ferr_set = w_stop_done & ~w_good;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= r_shift;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      // a new error in the clearing cycle wins
      r_ovf  <= (r_ovf & ~err_clr) | w_ovf_set;
      r_ferr <= (r_ferr & ~err_clr) | w_ferr_set;
    end
  end

  assign overflow  = r_ovf;
  assign frame_err = r_ferr;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed 8N1 frames at 16 clk/bit,
// queue-based byte model checked every idle cycle plus literal checks.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rd_en;
  logic       err_clr;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       overflow;
  logic       frame_err;

  uart_rx_fifo #(
    .SYS_CLK_FREQ(1600),
    .BAUD_RATE(100),
    .FIFO_ADDR_BITS(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .rd_en(rd_en),
    .err_clr(err_clr),
    .rd_data(rd_data),
    .empty(empty),
    .full(full),
    .count(count),
    .overflow(overflow),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  byte unsigned q[$];
  bit m_ovf = 0;
  bit m_ferr = 0;
  bit m_busy = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: pops/clears at idle clock edges, frames resolved by send_frame
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_ovf  = 0;
      m_ferr = 0;
    end else begin
      if (err_clr) begin
        m_ovf  = 0;
        m_ferr = 0;
      end
      if (!m_busy && rd_en && q.size() > 0) void'(q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (chk_en && !m_busy) begin
      chk("rd_data", 32'(rd_data), (q.size() > 0) ? 32'(q[0]) : 32'h0);
      chk("count", 32'(count), 32'(q.size()));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("full", 32'(full), 32'(q.size() == 8));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("frame_err", 32'(frame_err), 32'(m_ferr));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop1();
    rd_en = 1'b1;
    idle(1);
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                            input bit pop_at_push);
    logic [9:0] bits;
    bits = {stop_ok, b, 1'b0};
    m_busy = 1;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      for (int c = 0; c < 16; c++) begin
        rd_en = pop_at_push && (i == 9) && (c == 10);
        @(posedge clk);
        #1;
      end
    end
    rx = 1'b1;
    rd_en = 1'b0;
    if (pop_at_push && q.size() > 0) void'(q.pop_front());
    if (!stop_ok) m_ferr = 1;
    else if (q.size() < 8) q.push_back(b);
    else m_ovf = 1;
    m_busy = 0;
  endtask

  initial begin
    rx = 1'b1;
    rd_en = 1'b0;
    err_clr = 1'b0;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_rd_data", 32'(rd_data), 32'h0);
    chk("rst_flags", 32'({overflow, frame_err}), 32'h0);
    chk_en = 1;

    idle(5);
    send_frame(8'h55, 1, 0);
    idle(2);
    chk("t1_data", 32'(rd_data), 32'h55);
    chk("t1_count", 32'(count), 32'h1);
    chk("t1_empty", 32'(empty), 32'h0);
    pop1();
    chk("t1_popped", 32'(empty), 32'h1);

    send_frame(8'hA5, 1, 0);
    send_frame(8'h3C, 1, 0);
    idle(2);
    chk("t2_count", 32'(count), 32'h2);
    chk("t2_first", 32'(rd_data), 32'hA5);
    pop1();
    chk("t2_second", 32'(rd_data), 32'h3C);
    pop1();
    chk("t2_empty", 32'(empty), 32'h1);

    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(30);
    chk("t3_count", 32'(count), 32'h0);
    chk("t3_ferr", 32'(frame_err), 32'h0);

    send_frame(8'h81, 0, 0);
    idle(20);
    chk("t4_ferr", 32'(frame_err), 32'h1);
    chk("t4_count", 32'(count), 32'h0);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    chk("t4_clr", 32'(frame_err), 32'h0);

    for (int i = 0; i < 9; i++) send_frame(8'(i), 1, 0);
    idle(2);
    chk("t5_full", 32'(full), 32'h1);
    chk("t5_count", 32'(count), 32'h8);
    chk("t5_ovf", 32'(overflow), 32'h1);
    chk("t5_head", 32'(rd_data), 32'h0);
    do_reset();
    for (int i = 0; i < 8; i++) send_frame(8'(i), 1, 0);
    send_frame(8'h08, 1, 1);
    idle(2);
    chk("t5b_ovf", 32'(overflow), 32'h0);
    chk("t5b_count", 32'(count), 32'h8);
    chk("t5b_head", 32'(rd_data), 32'h1);
    for (int i = 1; i < 9; i++) begin
      chk("t5b_order", 32'(rd_data), 32'(i));
      pop1();
    end
    chk("t5b_empty", 32'(empty), 32'h1);

    send_frame(8'h11, 1, 0);
    m_busy = 1;
    rx = 1'b0;
    idle(16);
    rx = 1'b1;
    idle(16);
    rx = 1'b0;
    idle(16);
    rst = 1'b1;
    rx = 1'b1;
    idle(1);
    rst = 1'b0;
    m_busy = 0;
    chk("t6_count", 32'(count), 32'h0);
    chk("t6_empty", 32'(empty), 32'h1);
    chk("t6_rd_data", 32'(rd_data), 32'h0);
    chk("t6_flags", 32'({overflow, frame_err}), 32'h0);
    idle(10);
    send_frame(8'h7E, 1, 0);
    idle(2);
    chk("t6_data", 32'(rd_data), 32'h7E);
    chk("t6_cnt1", 32'(count), 32'h1);
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
